uart_rx_gen: RTL

Parametrised UART receive block: the successor to the fixed 8-bit, 16x-oversampled receiver. It adds configurable word length, oversample ratio, parity and stop bits, and per-word error status. The receive path deserialises the asynchronous serial line `uart_dataH` into parallel words. Each word is presented on a valid/ready holding register to the host-side logic, which sits in the same clock domain.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_sync.sv | 21 ++
 rtl/uart_rx_gen.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared receiver state type, parity codes and parameter check
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    DELIVER   = 3'd5,
    WAIT_IDLE = 3'd6
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic bit rx_params_ok(input int dataBits, input int overSample,
                                      input int parityMode, input int stopBits);
    return (dataBits >= 5) && (dataBits <= 9) &&
           (overSample >= 8) && (overSample <= 32) && (overSample % 2 == 0) &&
           (parityMode >= PAR_NONE) && (parityMode <= PAR_ODD) &&
           ((stopBits == 1) || (stopBits == 2));
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop synchroniser, resets to idle-high
module uart_rx_sync (
  input  logic clk_l,
  input  logic sys_rst_l,
  input  logic asyncH,
  output logic syncH
);

  logic metaH;

  always_ff @(posedge clk_l or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      metaH <= 1'b1;
      syncH <= 1'b1;
    end else begin
      metaH <= asyncH;
      syncH <= metaH;
    end
  end

endmodule

// File: rtl/uart_rx_gen.sv
// rtl/uart_rx_gen.sv - parametrised UART receiver with valid/ready holding register
// Optional break detection and WAIT_IDLE recovery: UART_RX_BREAK_DET_EN
module uart_rx_gen
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk_l,
  input  logic                 sys_rst_l,
  input  logic                 uart_dataH,
  output logic [DATA_BITS-1:0] rx_dataH,
  output logic                 rx_validH,
  input  logic                 rx_readyH,
  output logic                 parity_errH,
  output logic                 frame_errH,
  output logic                 overrunH
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic                 break_detH
`endif
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CELL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  if (!rx_params_ok(DATA_BITS, OVERSAMPLE, PARITY_MODE, STOP_BITS)) begin : gBadParams
    $error("uart_rx_gen: parameter set out of range");
  end

  rx_state_t            state;
  logic                 rxLineH;
  logic [CW-1:0]        cellCnt;
  logic [BW-1:0]        bitCnt;
  logic                 stopCnt;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 parErrR;
  logic                 frameErrR;
  logic                 cellEnd;

  uart_rx_sync uSync (
    .clk_l     (clk_l),
    .sys_rst_l (sys_rst_l),
    .asyncH    (uart_dataH),
    .syncH     (rxLineH)
  );

  assign cellEnd = (cellCnt == CELL_LAST);

`ifdef UART_RX_BREAK_DET_EN
  logic parBitR;
  logic stop1LowR;
  logic isBreak;
  assign isBreak = (shiftReg == '0) && ((PARITY_MODE == PAR_NONE) || !parBitR) && stop1LowR;
`endif

  always_ff @(posedge clk_l or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state       <= IDLE;
      cellCnt     <= '0;
      bitCnt      <= '0;
      stopCnt     <= 1'b0;
      shiftReg    <= '0;
      parErrR     <= 1'b0;
      frameErrR   <= 1'b0;
      rx_dataH    <= '0;
      rx_validH   <= 1'b0;
      parity_errH <= 1'b0;
      frame_errH  <= 1'b0;
      overrunH    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      parBitR     <= 1'b0;
      stop1LowR   <= 1'b0;
      break_detH  <= 1'b0;
`endif
    end else begin
      cellCnt  <= cellCnt + CW'(1);
      overrunH <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      break_detH <= 1'b0;
`endif
      if (rx_validH && rx_readyH) rx_validH <= 1'b0;

      case (state)
        IDLE: if (!rxLineH) begin
          state   <= START;
          cellCnt <= '0;
        end
        START: if (cellCnt == HALF_LAST) begin
          cellCnt   <= '0;
          state     <= rxLineH ? IDLE : DATA;
          bitCnt    <= '0;
          stopCnt   <= 1'b0;
          parErrR   <= 1'b0;
          frameErrR <= 1'b0;
        end
        // Counter is cleared at each sample so non-power-of-two ratios wrap correctly.
        DATA: if (cellEnd) begin
          cellCnt  <= '0;
          shiftReg <= {rxLineH, shiftReg[DATA_BITS-1:1]};
          bitCnt   <= bitCnt + BW'(1);
          if (bitCnt == BIT_LAST) state <= (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
        end
        PARITY: if (cellEnd) begin
          cellCnt <= '0;
          state   <= STOP;
          parErrR <= (PARITY_MODE == PAR_ODD) ? ~(^shiftReg ^ rxLineH) : (^shiftReg ^ rxLineH);
`ifdef UART_RX_BREAK_DET_EN
          parBitR <= rxLineH;
`endif
        end
        STOP: if (cellEnd) begin
          cellCnt <= '0;
          stopCnt <= 1'b1;
          if (!rxLineH) frameErrR <= 1'b1;
`ifdef UART_RX_BREAK_DET_EN
          if (!stopCnt) stop1LowR <= !rxLineH;
`endif
          if ((STOP_BITS == 1) || stopCnt) state <= DELIVER;
        end
        DELIVER: begin
          cellCnt <= '0;
          state   <= IDLE;
`ifdef UART_RX_BREAK_DET_EN
          if (isBreak) begin
            break_detH <= 1'b1;
            state      <= WAIT_IDLE;
          end else
`endif
          if (rx_validH && !rx_readyH) begin
            overrunH <= 1'b1;
          end else begin
            rx_dataH    <= shiftReg;
            parity_errH <= parErrR;
            frame_errH  <= frameErrR;
            rx_validH   <= 1'b1;
          end
        end
`ifdef UART_RX_BREAK_DET_EN
        WAIT_IDLE: begin
          if (!rxLineH) begin
            cellCnt <= '0;
          end else if (cellEnd) begin
            cellCnt <= '0;
            state   <= IDLE;
          end
        end
`endif
        default: begin
          state   <= IDLE;
          cellCnt <= '0;
        end
      endcase
    end
  end

endmodule
